regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 120 ++++++++++++
 tb/tb_regfile_sb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 1-write register file with a per-register busy
// scoreboard and a running count of busy registers.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data and busy-clear to the read ports.
module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] W_Adr,
    input  logic [DATA_W-1:0] W,
    input  logic [ADDR_W-1:0] R_Adr,
    input  logic [ADDR_W-1:0] S_Adr,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_Adr,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] S,
    output logic              R_busy,
    output logic              S_busy,
    output logic              stall,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic w_set_new;
    logic w_same_adr;
    logic w_clr_old;

    // A reserve on a clear bit adds one; a write clears a set bit unless the
    // same cycle re-reserves it (new producer keeps the register busy).
    assign w_set_new  = rsv & ~r_busy[rsv_Adr];
    assign w_same_adr = rsv & (rsv_Adr == W_Adr);
    assign w_clr_old  = we & r_busy[W_Adr] & ~w_same_adr;

    // Register storage: write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[W_Adr] <= W;
        end
    end

    // Busy bits: reserve is applied after write-clear so it wins on collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (we) begin
                r_busy[W_Adr] <= 1'b0;
            end
            if (rsv) begin
                r_busy[rsv_Adr] <= 1'b1;
            end
        end
    end

    // Busy counter tracks the popcount of r_busy incrementally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_cnt <= '0;
        end else begin
            case ({w_set_new, w_clr_old})
                2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
                2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
                default: r_busy_cnt <= r_busy_cnt;
            endcase
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_r_hit;
    logic w_s_hit;
    logic w_r_rsv;
    logic w_s_rsv;

    assign w_r_hit = we & (W_Adr == R_Adr);
    assign w_s_hit = we & (W_Adr == S_Adr);
    assign w_r_rsv = rsv & (rsv_Adr == R_Adr);
    assign w_s_rsv = rsv & (rsv_Adr == S_Adr);

    // Read ports with same-cycle write forwarding.
    always_comb begin
        R      = r_mem[R_Adr];
        S      = r_mem[S_Adr];
        R_busy = r_busy[R_Adr];
        S_busy = r_busy[S_Adr];
        if (w_r_hit) begin
            R      = W;
            R_busy = w_r_rsv;
        end
        if (w_s_hit) begin
            S      = W;
            S_busy = w_s_rsv;
        end
    end
`else
    // Read ports return stored contents and stored busy bits only.
    always_comb begin
        R      = r_mem[R_Adr];
        S      = r_mem[S_Adr];
        R_busy = r_busy[R_Adr];
        S_busy = r_busy[S_Adr];
    end
`endif

    assign stall    = R_busy | S_busy;
    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes the expected read-port
// view for each cycle; a negedge monitor pops and compares.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  W_Adr;
    logic [15:0] W;
    logic [2:0]  R_Adr;
    logic [2:0]  S_Adr;
    logic        rsv;
    logic [2:0]  rsv_Adr;
    logic [15:0] R;
    logic [15:0] S;
    logic        R_busy;
    logic        S_busy;
    logic        stall;
    logic [3:0]  busy_cnt;

    regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .we(we), .W_Adr(W_Adr), .W(W),
        .R_Adr(R_Adr), .S_Adr(S_Adr), .rsv(rsv), .rsv_Adr(rsv_Adr),
        .R(R), .S(S), .R_busy(R_busy), .S_busy(S_busy),
        .stall(stall), .busy_cnt(busy_cnt)
    );

    typedef struct {
        string       nm;
        logic [15:0] r;
        logic [15:0] s;
        logic        rb;
        logic        sb;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the DUT's combinational view mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (R !== e.r || S !== e.s || R_busy !== e.rb || S_busy !== e.sb ||
                stall !== (e.rb | e.sb) || busy_cnt !== e.cnt) begin
                n_errors++;
                $display("FAIL %s: got R=%h S=%h Rb=%b Sb=%b stall=%b cnt=%0d expected R=%h S=%h Rb=%b Sb=%b stall=%b cnt=%0d",
                         e.nm, R, S, R_busy, S_busy, stall, busy_cnt,
                         e.r, e.s, e.rb, e.sb, e.rb | e.sb, e.cnt);
            end
        end
    end

    task automatic drive(input logic rs, input logic w_e, input logic [2:0] wa,
                         input logic [15:0] wd, input logic rv, input logic [2:0] va,
                         input logic [2:0] ra, input logic [2:0] sa);
        @(posedge clk);
        #1;
        reset = rs; we = w_e; W_Adr = wa; W = wd;
        rsv = rv; rsv_Adr = va; R_Adr = ra; S_Adr = sa;
    endtask

    task automatic expect_o(input string nm, input logic [15:0] r, input logic [15:0] s,
                            input logic rb, input logic sb, input logic [3:0] cnt);
        exp_t e;
        e.nm = nm; e.r = r; e.s = s; e.rb = rb; e.sb = sb; e.cnt = cnt;
        q.push_back(e);
    endtask

    logic [15:0] regval [8];
    logic [15:0] newval [8];

    initial begin
        reset = 1'b1; we = 1'b0; W_Adr = '0; W = '0;
        rsv = 1'b0; rsv_Adr = '0; R_Adr = '0; S_Adr = '0;

        drive(1, 0, 0, 16'h0000, 0, 0, 0, 0);
        expect_o("reset_init", 16'h0000, 16'h0000, 0, 0, 0);

        // Write then dual-read of the same address.
        drive(0, 1, 5, 16'hA5A5, 0, 0, 0, 0);
        expect_o("wr5", 16'h0000, 16'h0000, 0, 0, 0);
        drive(0, 0, 0, 16'h0000, 0, 0, 5, 5);
        expect_o("rd5", 16'hA5A5, 16'hA5A5, 0, 0, 0);

        // Reserve 2 and 3, then complete 2.
        drive(0, 0, 0, 16'h0000, 1, 2, 2, 5);
        expect_o("rsv2", 16'h0000, 16'hA5A5, 0, 0, 0);
        drive(0, 0, 0, 16'h0000, 1, 3, 2, 3);
        expect_o("rsv3", 16'h0000, 16'h0000, 1, 0, 1);
        drive(0, 0, 0, 16'h0000, 0, 0, 2, 3);
        expect_o("cnt2", 16'h0000, 16'h0000, 1, 1, 2);
        drive(0, 1, 2, 16'h0042, 0, 0, 2, 5);
        expect_o("wr2", BYP ? 16'h0042 : 16'h0000, 16'hA5A5, !BYP, 0, 2);
        drive(0, 0, 0, 16'h0000, 0, 0, 2, 3);
        expect_o("after_wr2", 16'h0042, 16'h0000, 0, 1, 1);

        // Collision: we and rsv to the same busy register.
        drive(0, 0, 0, 16'h0000, 1, 4, 4, 3);
        expect_o("rsv4", 16'h0000, 16'h0000, 0, 1, 1);
        drive(0, 1, 4, 16'h1111, 1, 4, 4, 0);
        expect_o("coll", BYP ? 16'h1111 : 16'h0000, 16'h0000, 1, 0, 2);
        drive(0, 0, 0, 16'h0000, 0, 0, 4, 3);
        expect_o("after_coll", 16'h1111, 16'h0000, 1, 1, 2);

        // One set and one clear on different addresses in the same cycle.
        drive(0, 1, 3, 16'h3333, 1, 6, 6, 3);
        expect_o("swap", 16'h0000, BYP ? 16'h3333 : 16'h0000, 0, !BYP, 2);
        drive(0, 0, 0, 16'h0000, 0, 0, 6, 3);
        expect_o("after_swap", 16'h0000, 16'h3333, 1, 0, 2);

        // Write to a busy register read in the same cycle.
        drive(0, 0, 0, 16'h0000, 1, 1, 1, 4);
        expect_o("rsv1", 16'h0000, 16'h1111, 0, 1, 2);
        drive(0, 1, 1, 16'hBEEF, 0, 0, 1, 4);
        expect_o("byp1", BYP ? 16'hBEEF : 16'h0000, 16'h1111, !BYP, 1, 3);
        drive(0, 0, 0, 16'h0000, 0, 0, 1, 4);
        expect_o("after_byp1", 16'hBEEF, 16'h1111, 0, 1, 2);

        // Drain 4 and 6 so saturation starts from empty.
        drive(0, 1, 4, 16'h4444, 0, 0, 7, 7);
        expect_o("drain4", 16'h0000, 16'h0000, 0, 0, 2);
        drive(0, 1, 6, 16'h6666, 0, 0, 7, 7);
        expect_o("drain6", 16'h0000, 16'h0000, 0, 0, 1);
        drive(0, 0, 0, 16'h0000, 0, 0, 7, 7);
        expect_o("empty", 16'h0000, 16'h0000, 0, 0, 0);

        regval[0] = 16'h0000; regval[1] = 16'hBEEF; regval[2] = 16'h0042; regval[3] = 16'h3333;
        regval[4] = 16'h4444; regval[5] = 16'hA5A5; regval[6] = 16'h6666; regval[7] = 16'h0000;

        // Saturation: reserve every register.
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 16'h0000, 1, 3'(i), 3'(i), 3'(i));
            expect_o("sat_rsv", regval[i], regval[i], 0, 0, 4'(i));
        end
        drive(0, 0, 0, 16'h0000, 0, 0, 0, 7);
        expect_o("sat_full", 16'h0000, 16'h0000, 1, 1, 8);
        drive(0, 0, 0, 16'h0000, 1, 0, 0, 7);
        expect_o("sat_rsv0", 16'h0000, 16'h0000, 1, 1, 8);
        drive(0, 0, 0, 16'h0000, 0, 0, 0, 7);
        expect_o("sat_hold", 16'h0000, 16'h0000, 1, 1, 8);

        for (int i = 0; i < 8; i++) begin
            newval[i] = 16'h1000 + 16'(i) * 16'h0101;
            drive(0, 1, 3'(i), newval[i], 0, 0, 3'(i), 3'(i));
            expect_o("sat_wr", BYP ? newval[i] : regval[i], BYP ? newval[i] : regval[i],
                     !BYP, !BYP, 4'(8 - i));
        end
        drive(0, 0, 0, 16'h0000, 0, 0, 5, 7);
        expect_o("sat_drained", newval[5], newval[7], 0, 0, 0);

        // Asynchronous reset mid-cycle, with a write and reserve pending.
        drive(0, 0, 0, 16'h0000, 1, 5, 5, 7);
        expect_o("pre_rst", newval[5], newval[7], 0, 0, 0);
        drive(1, 1, 3, 16'hFFFF, 1, 2, 5, 2);
        expect_o("async_rst", 16'h0000, 16'h0000, 0, 0, 0);
        drive(0, 0, 0, 16'h0000, 0, 0, 3, 2);
        expect_o("post_rst", 16'h0000, 16'h0000, 0, 0, 0);

        drive(0, 0, 0, 16'h0000, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_queue: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
